seg_scan_display: RTL

//  Parametrised multiplexed seven-segment driver for the board top level. Scans N_DIGITS common-anode/cathode digits.

---
 rtl/seg_pkg.sv | 61 ++++++
 rtl/seg7_decode.sv | 18 +
 rtl/seg_scan_display.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared mode encodings, hex glyph table and BCD step helper for
//            the multiplexed seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Display mode as presented on the slt switches
  typedef enum logic [1:0] {
    MODE_EXT  = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DN   = 2'b10,
    MODE_LAMP = 2'b11
  } mode_e;

  // Glyphs {g,f,e,d,c,b,a}, 1 = segment lit; entry 0 is the rightmost field
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Every segment including the decimal point
  localparam logic [7:0] SEG_ALL_ON = 8'hFF;

  localparam int BCD_MAX_DIGITS = 8;

  // One BCD increment or decrement over the low n_digits digits.
  // The carry out of the top digit is dropped, so all-9s wraps to 0 and back.
  function automatic logic [31:0] bcd_step(input logic [31:0] val,
                                           input logic        up,
                                           input int          n_digits);
    logic [31:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (carry && (i < n_digits)) begin
        if (up) begin
          if (res[4*i +: 4] == 4'd9) begin
            res[4*i +: 4] = 4'd0;
          end else begin
            res[4*i +: 4] = res[4*i +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          if (res[4*i +: 4] == 4'd0) begin
            res[4*i +: 4] = 4'd9;
          end else begin
            res[4*i +: 4] = res[4*i +: 4] - 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational hex nibble to seven-segment glyph, 1 = lit.
//            Pin polarity is handled by the instantiating block.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_GLYPHS[nib_i];

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_display
// Purpose  : Multiplexed seven-segment scanner with PWM brightness and four
//            display modes (external hex, BCD up, BCD down, lamp test).
//            Inputs are sampled once per scan frame so a frame never tears.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_LOG2 = 16,
  parameter int BRIGHT_W     = 3,
  parameter int COUNT_DIV    = 50,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit SEL_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              slt,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [N_DIGITS-1:0]     led_sel,
  output logic [7:0]              led
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int CNT_W = 4 * N_DIGITS;

  // Pin levels that mean "off" for the chosen board polarity
  localparam logic [N_DIGITS-1:0] SEL_OFF = {N_DIGITS{SEL_ACT_LOW}};
  localparam logic [7:0]          SEG_OFF = {8{SEG_ACT_LOW}};

  logic [REFRESH_LOG2-1:0] presc_q;
  logic [IDX_W-1:0]        idx_q;
  mode_e                   mode_q;
  logic [CNT_W-1:0]        data_q;
  logic [N_DIGITS-1:0]     dp_q;
  logic [BRIGHT_W-1:0]     bright_q;
  logic [DIV_W-1:0]        div_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        disp_q;
  logic [N_DIGITS-1:0]     led_sel_q;
  logic [7:0]              led_q;

  logic                    slot_tick;
  logic                    frame_tick;
  logic                    pwm_on;
  logic [3:0]              nib_sel;
  logic [6:0]              glyph;
  logic [CNT_W-1:0]        cnt_step;
  logic [N_DIGITS-1:0]     sel_on;
  logic [7:0]              seg_on;
  logic [N_DIGITS-1:0]     led_sel_d;
  logic [7:0]              led_d;

  assign slot_tick  = &presc_q;
  assign frame_tick = slot_tick && (idx_q == IDX_W'(N_DIGITS - 1));

  // Top prescaler bits form the PWM ramp inside each digit slot
  assign pwm_on = (presc_q[REFRESH_LOG2-1 -: BRIGHT_W] <= bright_q);

  // Counter modes show the frame-sampled count, external mode the sampled data
  assign nib_sel = (mode_q == MODE_EXT) ? data_q[4*idx_q +: 4] : disp_q[4*idx_q +: 4];

  seg7_decode u_dec (
    .nib_i (nib_sel),
    .seg_o (glyph)
  );

  // Next BCD value in the direction of the mode currently in effect
  always_comb begin
    cnt_step = CNT_W'(bcd_step(32'(cnt_q), (mode_q == MODE_UP), N_DIGITS));
  end

  // Free-running prescaler and digit scan index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + REFRESH_LOG2'(1);
      if (slot_tick) begin
        idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Frame-boundary sampling, frame divider and BCD counter.
  // The displayed count is sampled before any step taken on the same tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_EXT;
      data_q   <= '0;
      dp_q     <= '0;
      bright_q <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
    end else if (frame_tick) begin
      mode_q   <= mode_e'(slt);
      data_q   <= data_in;
      dp_q     <= dp_in;
      bright_q <= brightness;
      disp_q   <= cnt_q;
      if ((mode_q == MODE_UP) || (mode_q == MODE_DN)) begin
        if (div_q == DIV_W'(COUNT_DIV - 1)) begin
          div_q <= '0;
          cnt_q <= cnt_step;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

  // Segment and digit-enable pattern for the current index and PWM phase
  always_comb begin
    sel_on = '0;
    seg_on = '0;
    if (pwm_on) begin
      sel_on[idx_q] = 1'b1;
      case (mode_q)
        MODE_EXT:         seg_on = {dp_q[idx_q], glyph};
        MODE_UP, MODE_DN: seg_on = {1'b0, glyph};
        default:          seg_on = SEG_ALL_ON;
      endcase
    end
    led_sel_d = sel_on ^ SEL_OFF;
    led_d     = seg_on ^ SEG_OFF;
  end

  // Registered pin drivers, blanked immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_sel_q <= SEL_OFF;
      led_q     <= SEG_OFF;
    end else begin
      led_sel_q <= led_sel_d;
      led_q     <= led_d;
    end
  end

  assign led_sel = led_sel_q;
  assign led     = led_q;

endmodule
`default_nettype wire
